// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad codes, debounce FSM states and frame-map decode
package keypad_pkg;

  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_HASH  = 4'd11;
  localparam logic [3:0] KEY_MULTI = 4'd14;
  localparam logic [3:0] KEY_NONE  = 4'd15;

  typedef enum logic {IDLE = 1'b0, PRESSED = 1'b1} kp_state_e;

  // Frame map bit index is row*3 + col, row 0 on top, col 0 on the left.
  function automatic logic [3:0] key_of_index(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd4;
      4'd4:    code = 4'd5;
      4'd5:    code = 4'd6;
      4'd6:    code = 4'd7;
      4'd7:    code = 4'd8;
      4'd8:    code = 4'd9;
      4'd9:    code = KEY_STAR;
      4'd10:   code = 4'd0;
      4'd11:   code = KEY_HASH;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] decode_frame(input logic [11:0] map);
    logic [3:0] code;
    logic [3:0] hits;
    code = KEY_NONE;
    hits = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (map[i]) begin
        hits = hits + 4'd1;
        code = key_of_index(4'(i));
      end
    end
    if (hits > 4'd1) begin
      code = KEY_MULTI;
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - frame-rate press/release debounce FSM with registered key outputs
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_frame_tick,
  input  logic [3:0] i_code,
  output logic [3:0] o_data,
  output logic       o_is_pressed,
  output logic       o_is_star_pressed,
  output logic       o_is_hash_pressed,
  output logic       o_key_strobe
);

  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  kp_state_e  r_state, w_state_next;
  logic [3:0] r_cand, w_cand_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic [3:0] r_acc, w_acc_next;
  logic [3:0] r_rel, w_rel_next;
  logic [3:0] r_data, w_data_next;
  logic       r_pressed, w_pressed_next;
  logic       r_star, w_star_next;
  logic       r_hash, w_hash_next;
  logic       r_strobe, w_strobe_next;
  logic       w_is_key;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cand    <= KEY_NONE;
      r_cnt     <= 4'd0;
      r_acc     <= KEY_NONE;
      r_rel     <= 4'd0;
      r_data    <= 4'd0;
      r_pressed <= 1'b0;
      r_star    <= 1'b0;
      r_hash    <= 1'b0;
      r_strobe  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cand    <= w_cand_next;
      r_cnt     <= w_cnt_next;
      r_acc     <= w_acc_next;
      r_rel     <= w_rel_next;
      r_data    <= w_data_next;
      r_pressed <= w_pressed_next;
      r_star    <= w_star_next;
      r_hash    <= w_hash_next;
      r_strobe  <= w_strobe_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cand_next    = r_cand;
    w_cnt_next     = r_cnt;
    w_acc_next     = r_acc;
    w_rel_next     = r_rel;
    w_data_next    = r_data;
    w_pressed_next = r_pressed;
    w_star_next    = r_star;
    w_hash_next    = r_hash;
    w_strobe_next  = 1'b0;
    w_is_key       = (i_code <= KEY_HASH);

    case (r_state)
      IDLE: begin
        if (i_frame_tick) begin
          if (w_is_key) begin
            if (i_code == r_cand) begin
              w_cnt_next = (r_cnt == DB) ? DB : r_cnt + 4'd1;
            end else begin
              w_cand_next = i_code;
              w_cnt_next  = 4'd1;
            end
          end else begin
            w_cand_next = KEY_NONE;
            w_cnt_next  = 4'd0;
          end

          if (w_is_key && w_cnt_next == DB) begin
            w_state_next  = PRESSED;
            w_acc_next    = i_code;
            w_rel_next    = 4'd0;
            w_strobe_next = 1'b1;
            if (i_code == KEY_STAR) begin
              w_star_next = 1'b1;
            end else if (i_code == KEY_HASH) begin
              w_hash_next = 1'b1;
            end else begin
              w_data_next    = i_code;
              w_pressed_next = 1'b1;
            end
          end
        end
      end

      PRESSED: begin
        // Anything but the accepted key, including a different key, counts as release.
        if (i_frame_tick) begin
          if (i_code != r_acc) begin
            if (r_rel + 4'd1 == DB) begin
              w_state_next   = IDLE;
              w_cand_next    = KEY_NONE;
              w_cnt_next     = 4'd0;
              w_rel_next     = 4'd0;
              w_pressed_next = 1'b0;
              w_star_next    = 1'b0;
              w_hash_next    = 1'b0;
            end else begin
              w_rel_next = r_rel + 4'd1;
            end
          end else begin
            w_rel_next = 4'd0;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_data            = r_data;
  assign o_is_pressed      = r_pressed;
  assign o_is_star_pressed = r_star;
  assign o_is_hash_pressed = r_hash;
  assign o_key_strobe      = r_strobe;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad column scanner with row sync, frame map and debounced outputs
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] data,
  output logic       is_pressed,
  output logic       is_star_pressed,
  output logic       is_hash_pressed,
  output logic       key_strobe
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  logic [3:0]    r_row_s1, r_row_s2;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_col;
  logic [2:0]    r_col_n;
  logic [11:0]   r_map;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [11:0]   w_col_hits;
  logic [11:0]   w_frame_map;
  logic [3:0]    w_code;

  assign w_slot_end  = (r_slot == SLOT_LAST);
  assign w_frame_end = w_slot_end && (r_col == 2'd2);

  always_comb begin
    w_col_hits = 12'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (2'(c) == r_col) begin
          w_col_hits[r*3 + c] = ~r_row_s2[r];
        end
      end
    end
  end

  // Column 2's sample is merged combinationally so the frame decodes in its last cycle.
  assign w_frame_map = r_map | (w_slot_end ? w_col_hits : 12'd0);
  assign w_code      = decode_frame(w_frame_map);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_s1 <= 4'b1111;
      r_row_s2 <= 4'b1111;
      r_slot   <= '0;
      r_col    <= 2'd0;
      r_col_n  <= 3'b110;
      r_map    <= 12'd0;
    end else begin
      r_row_s1 <= row_n;
      r_row_s2 <= r_row_s1;
      if (w_slot_end) begin
        r_slot  <= '0;
        r_col   <= (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
        r_col_n <= {r_col_n[1:0], r_col_n[2]};
        r_map   <= w_frame_end ? 12'd0 : w_frame_map;
      end else begin
        r_slot <= r_slot + SW'(1);
      end
    end
  end

  assign col_n = r_col_n;

  key_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk              (clk),
    .reset            (reset),
    .i_frame_tick     (w_frame_end),
    .i_code           (w_code),
    .o_data           (data),
    .o_is_pressed     (is_pressed),
    .o_is_star_pressed(is_star_pressed),
    .o_is_hash_pressed(is_hash_pressed),
    .o_key_strobe     (key_strobe)
  );

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4-row × 3-column telephone-style keypad and debounces it. Produces the 8421 BCD digit and the held-key levels that drive the password comparator (`data`, `is_pressed`, `is_star_pressed`), plus a `#` level for the safe controller. Sits directly upstream of the comparator. Every output is a debounced, glitch-free register, because the comparator clocks its length counter and input registers on the edges of these signals.

## Interface
Parameters:
- `SCAN_DIV`, default 4: clock cycles per column slot; must be ≥ 4 to cover synchroniser latency.
- `DEBOUNCE_SCANS`, default 3: consecutive identical frames required to accept a press or a release; range 1–15.

Ports:
- `clk` input 1: single system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `row_n` input 4: keypad rows, active-low, asynchronous, with an external pull-up; bit 0 is the top row.
- `col_n` output 3: column drive, active-low one-hot; bit 0 is the left column.
- `data` output 4: BCD of the last accepted digit; held until the next digit is accepted.
- `is_pressed` output 1: high while an accepted digit key is held.
- `is_star_pressed` output 1: high while an accepted `*` is held.
- `is_hash_pressed` output 1: high while an accepted `#` is held.
- `key_strobe` output 1: one-cycle pulse in the cycle any key becomes accepted.

## Operation
- **Keymap** (row, col):
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- **Internal codes:** 0–9 are digits, 10 is `*`, 11 is `#`, 15 is NONE, 14 is MULTI (two or more keys down in a frame).
- **Synchroniser:** `row_n` passes through a 2-flop synchroniser; its reset value is 4'b1111.
- **Column scan:**
  - A slot counter runs 0…SCAN_DIV−1 and advances the column 0→1→2→0.
  - `col_n` drives the current column low.
  - The synchronised rows are sampled into a 12-bit frame map in the last cycle of each slot.
  - The end of column 2's slot is the frame boundary. At that point the map is decoded to a single code and then cleared.
- **FSM state IDLE:**
  - If the frame code is a key (0–11) and equals the candidate, the counter increments, saturating at DEBOUNCE_SCANS. Otherwise the candidate becomes that key and the counter is set to 1.
  - If the frame code is NONE or MULTI, the candidate is cleared and the counter is set to 0.
  - When the counter reaches DEBOUNCE_SCANS, the FSM moves to PRESSED, the candidate becomes the accepted code, and the outputs update.
- **FSM state PRESSED:**
  - Any frame code not equal to the accepted code counts toward release. This includes NONE, MULTI and a different key.
  - A frame equal to the accepted code resets the release count to 0.
  - When the release count reaches DEBOUNCE_SCANS, the FSM returns to IDLE and clears the candidate.
  - A different key held through a release is re-debounced from zero in IDLE.
- **On acceptance:**
  - For a digit, `data` ← digit and `is_pressed` ← 1.
  - For `*`, `is_star_pressed` ← 1.
  - For `#`, `is_hash_pressed` ← 1.
  - `key_strobe` pulses for one cycle.
  - `data` is unchanged for `*` and `#`.
- **On release:** all three level outputs are 0. `data` is retained.
- **Exclusivity:** at most one of `is_pressed`, `is_star_pressed`, `is_hash_pressed` is high at any time.

## Timing
- **Reset values:**
  - `col_n` = 3'b110.
  - `data` = 0.
  - All level outputs = 0 and `key_strobe` = 0.
  - FSM in IDLE.
  - Slot counter, column, counters and frame map = 0.
- **Reset mid-press:** outputs drop in the cycle after reset is sampled, with no `key_strobe`. The press is re-debounced from zero after reset deasserts.
- **Frame period:** 3 × SCAN_DIV cycles.
- **Row sampling:** rows are sampled SCAN_DIV−1 cycles after `col_n` changes; with 2-flop sync this requires SCAN_DIV ≥ 4.
- **Outputs are registered:** they change in the cycle after the accepting or releasing frame boundary.
- **Press latency:** for a key held stable from before a frame starts, the outputs rise 1 cycle after the DEBOUNCE_SCANS-th frame boundary.
- **Release latency:** the same figure, counted on the release.
- **Short presses:** a press shorter than DEBOUNCE_SCANS full frames is never accepted, and no `key_strobe` is issued.
- **`key_strobe` alignment:** it is coincident with the rising output level.

## Structure
- **Package `keypad_pkg`:**
  - Code constants: KEY_STAR = 10, KEY_HASH = 11, KEY_MULTI = 14, KEY_NONE = 15.
  - FSM state enum {IDLE, PRESSED}.
  - Keymap decode function (frame map → code).
- **Sub-module `key_debounce`:**
  - Contains the code-in / frame-tick FSM, the candidate and release counters, and the output registers.
- **Top level `keypad_scanner`:**
  - Contains the synchroniser, column scan, frame map and decode.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_SCANS = 3, giving a 12-cycle frame.
- **Reset:** assert `reset` for 2 cycles with `row_n` = 4'b0000 → `col_n` = 3'b110, all outputs 0, no `key_strobe` until 3 frames after reset deasserts.
- **Digit 5 (r1, c1):** hold for 5 frames → 1 cycle after the 3rd frame boundary, `data` = 4'd5, `is_pressed` = 1 and `key_strobe` is a single pulse. On release, `is_pressed` falls 3 frames + 1 cycle later and `data` stays 5.
- **`*` (r3, c0) after digit 5:** `is_star_pressed` = 1, `is_pressed` = 0, `data` remains 5. Then `#` (r3, c2): only `is_hash_pressed` rises.
- **Bounce:** key 0 (r3, c1) toggling each frame for 6 frames, then held → accepted exactly once, 3 frames after the hold starts; `data` = 0; exactly one `key_strobe`.
- **Multi-key:** keys 1 and 9 held together for 6 frames → no output change, no strobe. Then release 9 → key 1 is accepted after 3 frames.
- **Key swap and reset:**
  - Hold 7 (accepted), then switch directly to 8 → `is_pressed` drops after 3 frames and rises with `data` = 8 after 3 more frames.
  - Assert `reset` mid-press → outputs 0 in the next cycle.
